alu_mdu_iter: RTL
=================

Name: alu_mdu_iter

Overview:
- Parametrised execute-stage unit: all base integer ALU ops plus the RV32M multiply/divide/remainder ops, with internal operand selection (PC/immediate).
- Base ops complete in 1 cycle with a registered result.
- M ops use a radix-2 iterative engine: shift-add for multiply, restoring division for divide/remainder.
- A valid/ready handshake lets the pipeline stall on o_ready low; i_flush aborts an in-flight op on branch mispredict.

Parameters:
- XLEN, 32: datapath width (32 or 64); shift amount is operand_b[$clog2(XLEN)-1:0].
- MDU_EN, 1: 1 = iterative multiply/divide present; 0 = M opcodes complete in 1 cycle with result 0.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  op request; accepted on an edge where i_valid && o_ready && !i_flush.
- o_ready  out  1  unit can accept an op this cycle.
- i_flush  in  1  synchronous abort of any in-flight op.
- i_op  in  5  operation code (package enum).
- i_operand_a, i_operand_b  in  XLEN  rs1/rs2 data.
- i_op_a_sel  in  1  1 selects i_pc as operand A.
- i_op_b_sel  in  1  1 selects i_imm as operand B.
- i_pc, i_imm  in  XLEN  PC and sign-extended immediate.
- o_valid  out  1  one-cycle pulse; o_result is valid.
- o_result  out  XLEN  result, held until the next o_valid.
- o_busy  out  1  M op in flight (hazard unit stall).

Behaviour:
- Reset (async, i_rst_n=0): state IDLE, o_valid=0, o_result=0, o_busy=0, counter=0, o_ready=1 once reset is released.
- Opcodes: 00000 add, 00001 sub, 00010 and, 00011 or, 00100 sll, 00101 slt, 00111 sra, 01000 sltu, 01010 xor, 01011 srl, 01100 lui (result = operand B), 10000 mul, 10001 mulh, 10010 mulhsu, 10011 mulhu, 10100 div, 10101 divu, 10110 rem, 10111 remu. Any other code: result 0, 1-cycle latency.
- slt/sltu are computed internally from a signed/unsigned compare; there is no external less-than input.
- Base op: accepted at edge E0, o_result registered at E0, o_valid=1 in the following cycle. o_ready stays 1, so back-to-back ops are accepted every cycle.
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE + accepted M op:
  - latch absolute values of the operands per signedness (mulh: both signed; mulhsu: A signed, B unsigned; div/rem: both signed);
  - latch the result sign and which half is selected;
  - counter = XLEN-1; go to MUL or DIV; o_ready=0, o_busy=1.
- MUL/DIV: one iteration per edge (2*XLEN-bit product, or quotient/remainder pair); counter decrements; at counter==0 go to FIX.
- FIX: negate per the latched sign, select lo/hi product or quotient/remainder, register o_result, go to IDLE; o_valid=1 the next cycle.
- M-op latency: result edge is XLEN+1 edges after E0, i.e. 34 cycles from the accept cycle to o_valid for XLEN=32. Latency is fixed regardless of operand values.
- o_ready is 1 in the cycle o_valid pulses for an M op, so a new op may be accepted that same cycle.
- Divide by zero: quotient = all ones, remainder = dividend (same latency).
- Signed overflow (MIN / -1): quotient = MIN, remainder = 0 (same latency).
- i_flush: at the next edge go to IDLE, o_busy=0, no o_valid for the aborted op, o_result unchanged. Flush and i_valid in the same cycle: flush wins, nothing is accepted.
- Flush while idle: no effect, except it suppresses acceptance that cycle.
- Reset mid-operation: immediate return to the reset values; the op is lost.
- Operand muxes are applied only at acceptance; the M engine works from latched copies, so inputs may change while busy.

Decomposition:
- Package alu_pkg:
  - alu_op_e enum (5-bit codes above);
  - helpers is_mdu_op and is_signed_a/b;
  - constants DIV0_Q (all ones) and RESET_RESULT.
- Sub-module mdu_iter: the MUL/DIV/FIX FSM, counter and datapath registers, with start/done/abort interface.
- The top level holds the operand muxes, the single-cycle ALU, and output muxing and registration.

Test Plan:
- add/sub/slt in back-to-back cycles: a=5,b=-3 → results 2, 8, 0; slt a=-3,b=5 → 1. o_valid every cycle, o_ready constantly 1.
- Shifts and operand selects: sra with a=0x80000000, b=31 → 0xFFFFFFFF. srl with a=i_pc=0x100, i_op_b_sel=1, imm=4 → 0x10.
- mulh a=0xFFFFFFFF, b=0xFFFFFFFF → 0x00000000. mulhu on the same operands → 0xFFFFFFFE. Each takes 34 cycles, o_ready=0 throughout, one o_valid pulse.
- Division corner cases:
  - div 7/0 → 0xFFFFFFFF;
  - rem 7/0 → 7;
  - div 0x80000000/-1 → 0x80000000;
  - rem 0x80000000/-1 → 0;
  - div -7/2 → -3;
  - rem -7/2 → -1.
- Flush at iteration 10 of a divu: no o_valid, o_result unchanged, o_ready=1 the next cycle. A subsequent add completes normally.
- Assert i_rst_n low during a mul: outputs clear asynchronously. After release, a new mul 6*7 → 42 at 34 cycles.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encoding, MDU state encoding and helper functions for the
// execute-stage ALU/MDU.
package alu_pkg;

    typedef enum logic [4:0] {
        OP_ADD    = 5'b00000,
        OP_SUB    = 5'b00001,
        OP_AND    = 5'b00010,
        OP_OR     = 5'b00011,
        OP_SLL    = 5'b00100,
        OP_SLT    = 5'b00101,
        OP_SRA    = 5'b00111,
        OP_SLTU   = 5'b01000,
        OP_XOR    = 5'b01010,
        OP_SRL    = 5'b01011,
        OP_LUI    = 5'b01100,
        OP_MUL    = 5'b10000,
        OP_MULH   = 5'b10001,
        OP_MULHSU = 5'b10010,
        OP_MULHU  = 5'b10011,
        OP_DIV    = 5'b10100,
        OP_DIVU   = 5'b10101,
        OP_REM    = 5'b10110,
        OP_REMU   = 5'b10111
    } alu_op_e;

    typedef enum logic [1:0] {
        MDU_IDLE,
        MDU_MUL,
        MDU_DIV,
        MDU_FIX
    } mdu_state_e;

    // Wide enough for XLEN=64; users slice [XLEN-1:0].
    localparam logic [63:0] DIV0_Q       = '1;
    localparam logic [63:0] RESET_RESULT = '0;

    function automatic logic is_mdu_op(input logic [4:0] op);
        return op[4];
    endfunction

    function automatic logic is_div_op(input logic [4:0] op);
        return op[4] && op[2];
    endfunction

    function automatic logic is_signed_a(input logic [4:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_b(input logic [4:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/mdu_iter.sv
// Radix-2 iterative multiply/divide engine: shift-add multiply, restoring
// divide, one bit per clock, fixed XLEN+1 cycle occupancy per operation.
module mdu_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic            i_abort,
    input  logic [4:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_ready,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);
    localparam int CW = $clog2(XLEN);

    mdu_state_e        state_q, state_d;
    logic [CW-1:0]     cnt_q;
    logic [4:0]        op_q;
    logic              neg_q, div0_q;
    logic [XLEN-1:0]   mcand_q;
    // Multiply: {hi, lo} product. Divide: {remainder, quotient/dividend}.
    logic [2*XLEN-1:0] prod_q, prod_next, prod_signed;

    logic              a_neg, b_neg, div_ge;
    logic [XLEN-1:0]   abs_a, abs_b, quot, rem, div_diff;
    logic [XLEN:0]     add_sum, div_shift;

    assign a_neg = is_signed_a(i_op) && i_a[XLEN-1];
    assign b_neg = is_signed_b(i_op) && i_b[XLEN-1];
    assign abs_a = a_neg ? -i_a : i_a;
    assign abs_b = b_neg ? -i_b : i_b;

    always_comb begin
        state_d = state_q;
        case (state_q)
            MDU_IDLE: if (i_start) state_d = is_div_op(i_op) ? MDU_DIV : MDU_MUL;
            MDU_MUL,
            MDU_DIV:  if (cnt_q == '0) state_d = MDU_FIX;
            MDU_FIX:  state_d = MDU_IDLE;
            default:  state_d = MDU_IDLE;
        endcase
        if (i_abort) state_d = MDU_IDLE;
    end

    always_comb begin
        add_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        div_shift = prod_q[2*XLEN-1:XLEN-1];
        div_ge    = div_shift >= {1'b0, mcand_q};
        // The partial remainder is below 2^XLEN whenever the trial subtraction succeeds.
        div_diff  = div_shift[XLEN-1:0] - mcand_q;
        prod_next = prod_q;
        if (state_q == MDU_MUL)
            prod_next = {add_sum, prod_q[XLEN-1:1]};
        else if (state_q == MDU_DIV)
            prod_next = {(div_ge ? div_diff : div_shift[XLEN-1:0]), prod_q[XLEN-2:0], div_ge};
    end

    always_comb begin
        prod_signed = neg_q ? -prod_q : prod_q;
        quot        = prod_q[XLEN-1:0];
        rem         = prod_q[2*XLEN-1:XLEN];
        o_result    = '0;
        case (op_q)
            OP_MUL:                        o_result = prod_signed[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  o_result = prod_signed[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               o_result = div0_q ? DIV0_Q[XLEN-1:0] : (neg_q ? -quot : quot);
            OP_REM, OP_REMU:               o_result = neg_q ? -rem : rem;
            default:                       o_result = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= MDU_IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q   <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            div0_q  <= 1'b0;
            mcand_q <= '0;
            prod_q  <= '0;
        end else begin
            case (state_q)
                MDU_IDLE: if (i_start) begin
                    op_q    <= i_op;
                    prod_q  <= {{XLEN{1'b0}}, abs_a};
                    mcand_q <= abs_b;
                    // Remainder takes the dividend's sign; everything else the product of signs.
                    neg_q   <= (i_op == OP_REM) ? a_neg : (a_neg ^ b_neg);
                    div0_q  <= (i_b == '0);
                    cnt_q   <= CW'(XLEN - 1);
                end
                MDU_MUL, MDU_DIV: begin
                    prod_q <= prod_next;
                    cnt_q  <= cnt_q - CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign o_ready = (state_q == MDU_IDLE);
    assign o_busy  = !o_ready;
    assign o_done  = (state_q == MDU_FIX) && !i_abort;

endmodule

// File: rtl/alu_mdu_iter.sv
// Execute-stage unit: operand selection, single-cycle base ALU and an
// optional iterative multiply/divide engine behind a valid/ready handshake.
module alu_mdu_iter
    import alu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int MDU_EN = 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic            i_flush,
    input  logic [4:0]      i_op,
    input  logic [XLEN-1:0] i_operand_a,
    input  logic [XLEN-1:0] i_operand_b,
    input  logic            i_op_a_sel,
    input  logic            i_op_b_sel,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_imm,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result,
    output logic            o_busy
);
    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0] op_a, op_b, alu_res, mdu_result;
    logic [SHW-1:0]  shamt;
    logic            accept, mdu_start, mdu_done, mdu_ready, mdu_busy;

    assign op_a  = i_op_a_sel ? i_pc  : i_operand_a;
    assign op_b  = i_op_b_sel ? i_imm : i_operand_b;
    assign shamt = op_b[SHW-1:0];

    // Flush has priority over a request presented in the same cycle.
    assign accept    = i_valid && o_ready && !i_flush;
    assign mdu_start = accept && is_mdu_op(i_op) && (MDU_EN != 0);

    always_comb begin
        // NOTE: default first so every path assigns alu_res; otherwise a latch is inferred.
        alu_res = '0;
        case (i_op)
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_SLL:  alu_res = op_a << shamt;
            OP_SRL:  alu_res = op_a >> shamt;
            OP_SRA:  alu_res = $signed(op_a) >>> shamt;
            OP_SLT:  alu_res = XLEN'($signed(op_a) < $signed(op_b));
            OP_SLTU: alu_res = XLEN'(op_a < op_b);
            OP_LUI:  alu_res = op_b;
            default: alu_res = '0;
        endcase
    end

    if (MDU_EN != 0) begin : g_mdu
        mdu_iter #(.XLEN(XLEN)) u_mdu (
            .i_clk    (i_clk),
            .i_rst_n  (i_rst_n),
            .i_start  (mdu_start),
            .i_abort  (i_flush),
            .i_op     (i_op),
            .i_a      (op_a),
            .i_b      (op_b),
            .o_ready  (mdu_ready),
            .o_busy   (mdu_busy),
            .o_done   (mdu_done),
            .o_result (mdu_result)
        );
    end else begin : g_no_mdu
        assign mdu_ready  = 1'b1;
        assign mdu_busy   = 1'b0;
        assign mdu_done   = 1'b0;
        assign mdu_result = '0;
    end

    assign o_ready = mdu_ready;
    assign o_busy  = mdu_busy;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid  <= 1'b0;
            o_result <= RESET_RESULT[XLEN-1:0];
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            o_valid <= 1'b0;
            if (mdu_done) begin
                o_valid  <= 1'b1;
                o_result <= mdu_result;
            end else if (accept && !mdu_start) begin
                o_valid  <= 1'b1;
                o_result <= alu_res;
            end
        end
    end

endmodule
